// File: rtl/aes_stream_packer.sv
// Streams an accepted 128-bit key/plaintext pair into a word FIFO as 16 byte-pair
// words, MSB first. The last word carries FLAG in its upper half.
module aes_stream_packer #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] FLAG       = 16'h1111,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [127:0]          req_key,
    input  logic [127:0]          req_data,
    input  logic                  data_full,
    output logic                  data_wr,
    output logic [DATA_WIDTH-1:0] data_dout,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  blk_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [127:0]          key_q, key_d;
    logic [127:0]          pt_q, pt_d;
    logic [3:0]            idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]           word;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            pt_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        pt_d      = pt_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        data_wr   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        word      = 32'h0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    key_d   = req_key;
                    pt_d    = req_data;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy    = 1'b1;
                data_wr = !data_full;
                word    = {(idx_q == 4'hF) ? FLAG : 16'h0, key_q[127:120], pt_q[127:120]};
                // A stalled cycle leaves everything untouched so the same word is re-presented.
                if (!data_full) begin
                    key_d = {key_q[119:0], 8'h00};
                    pt_d  = {pt_q[119:0], 8'h00};
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'hF) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_dout = DATA_WIDTH'(word);
    assign blk_count = cnt_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Scoreboarded bench for aes_stream_packer: table of block vectors plus
// back-to-back, mid-block reset and counter-wrap sequences.
module tb_aes_stream_packer;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_key;
    logic [127:0] req_data;
    logic         data_full;
    logic         data_wr;
    logic [31:0]  data_dout;
    logic         busy;
    logic         done;
    logic [3:0]   blk_count;

    always #5 clock = ~clock;

    aes_stream_packer #(
        .DATA_WIDTH(32),
        .FLAG      (16'h1111),
        .CNT_WIDTH (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_key  (req_key),
        .req_data (req_data),
        .data_full(data_full),
        .data_wr  (data_wr),
        .data_dout(data_dout),
        .busy     (busy),
        .done     (done),
        .blk_count(blk_count)
    );

    int          total = 0;
    int          bad   = 0;
    int          wr_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wr_log[$];
    logic [3:0]  exp_blk = 4'd0;

    localparam logic [127:0] NOM_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NOM_PT  = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        logic [127:0] k;
        logic [127:0] d;
        logic [31:0]  mask;
        bit           tgl;
        int           lat;
    } vec_t;

    vec_t tv[5];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [127:0] k, input logic [127:0] d, input int i);
        logic [127:0] ks;
        logic [127:0] ds;
        ks = k << (8 * i);
        ds = d << (8 * i);
        return {(i == 15) ? 16'h1111 : 16'h0000, ks[127:120], ds[127:120]};
    endfunction

    // Every observed write must match the oldest outstanding expected word.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && data_wr === 1'b1) begin
            wr_cnt++;
            wr_log.push_back(data_dout);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write", data_dout);
            end else begin
                check("wr_word", {96'h0, data_dout}, {96'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        data_full = 1'b0;
        req_key   = '0;
        req_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_wr", data_wr, 1'b0);
        check("rst_dout", data_dout, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_cnt", blk_count, 4'h0);
        exp_q.delete();
        exp_blk = 4'd0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clock);
            if (done === 1'b1) break;
            check({nm, "_ready_low"}, req_ready, 1'b0);
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
        end
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] d, input logic [31:0] mask,
                              input bit tgl, input int exp_lat, input string nm);
        int  n;
        int  lat;
        bit  seen;
        req_key   = k;
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL %s_ready: got 0 expected 1 within 50 cycles", nm);
            req_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(model_word(k, d, i));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (tgl) begin
            req_key  = ~k;
            req_data = ~d;
        end
        lat  = 0;
        seen = 1'b0;
        while (lat < 60 && !seen) begin
            data_full = (lat < 32) ? mask[lat] : 1'b0;
            if (tgl) req_valid = lat[0];
            lat++;
            @(negedge clock);
            check({nm, "_busy"}, busy, 1'b1);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                check({nm, "_ready_low"}, req_ready, 1'b0);
                if (data_full && exp_q.size() > 0) begin
                    check({nm, "_stall_wr"}, data_wr, 1'b0);
                    check({nm, "_stall_hold"}, data_dout, exp_q[0]);
                end
                @(posedge clock);
                #1;
            end
        end
        req_valid = 1'b0;
        data_full = 1'b0;
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_drained"}, exp_q.size(), 0);
        exp_blk = exp_blk + 4'd1;
        @(posedge clock);
        #1;
        check({nm, "_idle_ready"}, req_ready, 1'b1);
        check({nm, "_idle_busy"}, busy, 1'b0);
        check({nm, "_done_pulse"}, done, 1'b0);
        check({nm, "_idle_wr"}, data_wr, 1'b0);
        check({nm, "_idle_dout"}, data_dout, 32'h0);
        check({nm, "_cnt"}, blk_count, exp_blk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wr0;

        tv[0] = '{k: NOM_KEY, d: NOM_PT, mask: 32'h0000_0000, tgl: 1'b0, lat: 17};
        tv[1] = '{k: NOM_KEY, d: NOM_PT, mask: 32'h0000_0038, tgl: 1'b0, lat: 20};
        tv[2] = '{k: 128'hdeadbeef_01234567_89abcdef_cafef00d, d: 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0,
                  mask: 32'h0000_8001, tgl: 1'b0, lat: 19};
        tv[3] = '{k: 128'h11223344_55667788_99aabbcc_ddeeff00, d: 128'hffeeddcc_bbaa9988_77665544_33221100,
                  mask: 32'h0000_0000, tgl: 1'b1, lat: 17};
        tv[4] = '{k: 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, d: 128'h80000000_00000000_00000000_00000001,
                  mask: 32'h0001_0000, tgl: 1'b0, lat: 17};

        do_reset();

        for (int t = 0; t < 5; t++) begin
            base = wr_log.size();
            send_block(tv[t].k, tv[t].d, tv[t].mask, tv[t].tgl, tv[t].lat, $sformatf("vec%0d", t));
            check($sformatf("vec%0d_writes", t), wr_log.size() - base, 16);
            if (t < 2) begin
                check($sformatf("vec%0d_w0", t), wr_log[base], 32'h0000_0000);
                check($sformatf("vec%0d_w3", t), wr_log[base + 3], 32'h0000_0333);
                check($sformatf("vec%0d_w15", t), wr_log[base + 15], 32'h1111_0FFF);
            end
        end

        // Back-to-back: req_valid stays high across both blocks.
        wr0 = wr_cnt;
        req_key   = NOM_KEY;
        req_data  = NOM_PT;
        req_valid = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(model_word(NOM_KEY, NOM_PT, i));
        @(posedge clock);
        #1;
        req_key  = tv[2].k;
        req_data = tv[2].d;
        wait_done("b2b_a");
        for (int i = 0; i < 16; i++) exp_q.push_back(model_word(tv[2].k, tv[2].d, i));
        @(posedge clock);
        #1;
        check("b2b_reentry_ready", req_ready, 1'b1);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("b2b_b_first_wr", data_wr, 1'b1);
        check("b2b_b_first_word", data_dout, model_word(tv[2].k, tv[2].d, 0));
        @(posedge clock);
        #1;
        wait_done("b2b_b");
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        exp_blk = exp_blk + 4'd2;
        check("b2b_writes", wr_cnt - wr0, 32);
        check("b2b_cnt", blk_count, exp_blk);
        check("b2b_idle_ready", req_ready, 1'b1);

        // Reset asserted after 7 writes of a block.
        wr0 = wr_cnt;
        req_key   = tv[3].k;
        req_data  = tv[3].d;
        req_valid = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(model_word(tv[3].k, tv[3].d, i));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_writes", wr_cnt - wr0, 7);
        check("mid_rst_wr", data_wr, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cnt", blk_count, 4'h0);
        check("mid_rst_dout", data_dout, 32'h0);
        check("mid_rst_ready", req_ready, 1'b1);
        exp_q.delete();
        exp_blk = 4'd0;
        repeat (2) @(negedge clock);
        check("mid_rst_no_wr", wr_cnt - wr0, 7);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        base = wr_log.size();
        send_block(NOM_KEY, NOM_PT, 32'h0, 1'b0, 17, "post_rst");
        check("post_rst_w0", wr_log[base], 32'h0000_0000);
        check("post_rst_w1", wr_log[base + 1], 32'h0000_0111);

        // Counter wrap with a 4-bit blk_count.
        do_reset();
        for (int b = 1; b <= 16; b++) begin
            send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                       32'h0, 1'b0, 17, $sformatf("wrap%0d", b));
            if (b == 15) check("wrap_cnt_15", blk_count, 4'hF);
            if (b == 16) check("wrap_cnt_16", blk_count, 4'h0);
        end

        repeat (3) @(posedge clock);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_stream_packer.md
AES_STREAM_PACKER -- requirements
Module: aes_stream_packer

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, default 32, FIFO word width.
- FLAG, default 16'h1111, last-word marker placed in bits [31:16].
- CNT_WIDTH, default 16, width of blk_count.
REQ-002 Ports SHALL be, one per line:
- clock, input, 1, sole clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, key/plaintext request valid.
- req_ready, output, 1, block can accept a request.
- req_key, input, 128, AES key, byte [127:120] first.
- req_data, input, 128, plaintext, byte [127:120] first.
- data_full, input, 1, downstream input FIFO full.
- data_wr, output, 1, FIFO write strobe.
- data_dout, output, DATA_WIDTH, FIFO write word.
- busy, output, 1, block transfer in progress.
- done, output, 1, one-cycle pulse when a block has been fully written.
- blk_count, output, CNT_WIDTH, count of completed blocks.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low on reset_n.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-005 req_ready SHALL be 1 only in IDLE.
REQ-006 A request SHALL be accepted only on a rising edge where req_valid and req_ready are both 1.
REQ-007 On acceptance, req_key and req_data SHALL be latched into internal shift registers, word index SHALL be set to 0, and the state SHALL move to SEND; later changes on req_* SHALL have no effect until the next acceptance.
REQ-008 In SEND, data_wr SHALL equal !data_full, combinationally, within the same cycle.
REQ-009 In SEND, data_dout[15:8] SHALL be the current key byte and data_dout[7:0] SHALL be the current plaintext byte, both taken from the MSB end of the shift registers.
REQ-010 In SEND, data_dout[31:16] SHALL be FLAG when index == 15, else 0.
REQ-011 On each cycle with data_wr = 1, both shift registers SHALL shift left 8 bits and index SHALL increment.
REQ-012 A write at index 15 SHALL move the FSM to DONE.
REQ-013 While data_full = 1, index, the shift registers and data_dout SHALL hold stable, and no word SHALL be skipped or duplicated.
REQ-014 Exactly 16 writes SHALL occur per accepted block, in byte order [127:120] down to [7:0].
REQ-015 DONE SHALL last one cycle: done = 1, blk_count increments (wrapping from all-ones to 0), then the FSM returns to IDLE.
REQ-016 busy SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-017 Outside SEND, data_wr SHALL be 0 and data_dout SHALL be 0.
REQ-018 Minimum latency SHALL be: first data_wr in the cycle after acceptance, done 16 cycles later with no stalls, req_ready back 1 cycle after done; throughput is 18 cycles per block.
REQ-019 With req_valid held high continuously, consecutive blocks SHALL be accepted with no gap beyond REQ-018.

Reset
REQ-020 While reset_n = 0, state SHALL be IDLE, index and the shift registers SHALL be 0, and blk_count SHALL be 0.
REQ-021 While reset_n = 0, outputs SHALL be data_wr = 0, data_dout = 0, done = 0, busy = 0 and req_ready = 1.
REQ-022 Reset asserted mid-block SHALL abort the transfer immediately with no further writes; the next accepted request SHALL start at word 0.

Verification
REQ-023 Nominal vector: req_key = 000102030405060708090a0b0c0d0e0f, req_data = 00112233445566778899aabbccddeeff, data_full = 0 -> data_wr is 1 for 16 cycles with words 0x00000000, 0x00000111, 0x00000222, ..., 0x00000EEE, 0x11110FFF; done pulses once; blk_count = 1.
REQ-024 Stall: same vector with data_full = 1 during the 4th, 5th and 6th SEND cycles -> data_wr = 0 in those cycles, data_dout holds 0x00000333, the same 16 words follow in order, and done is 3 cycles later than in REQ-023.
REQ-025 Back-to-back: req_valid held high with two different vectors -> 32 writes total; the second block's first word follows its acceptance one cycle after IDLE re-entry; blk_count = 2; req_ready = 0 throughout both SEND phases.
REQ-026 Reset mid-block: assert reset_n = 0 after 7 writes -> data_wr = 0, busy = 0 and blk_count = 0 immediately; after release a new request emits word 0x00000000 first.
REQ-027 Counter wrap: with CNT_WIDTH = 4, send 16 blocks -> blk_count reads 0xF after the 15th done and 0x0 after the 16th done.
REQ-028 Request during busy: toggle req_valid and change req_key while in SEND -> output words are unaffected, and no extra acceptance occurs before IDLE.
